// File: rtl/alu_issue_unit.sv
// alu_issue_unit: ALU request issue stage with a 2-entry in-order response queue.
// Requests are registered into an execute (X) stage that drives the ALU.
// The ALU result, tagged with the request tag, is written into the response queue.
module alu_issue_unit #(
  parameter int unsigned nbits = 32,
  parameter int unsigned tbits = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic             req_op,
  input  logic [nbits-1:0] req_in0,
  input  logic [nbits-1:0] req_in1,
  input  logic [tbits-1:0] req_tag,
  output logic             alu_op,
  output logic [nbits-1:0] alu_in0,
  output logic [nbits-1:0] alu_in1,
  input  logic [nbits-1:0] alu_out,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [nbits-1:0] resp_data,
  output logic [tbits-1:0] resp_tag,
  output logic [1:0]       occ
);

  logic             x_val_q, x_val_d;
  logic             x_op_q, x_op_d;
  logic [nbits-1:0] x_in0_q, x_in0_d;
  logic [nbits-1:0] x_in1_q, x_in1_d;
  logic [tbits-1:0] x_tag_q, x_tag_d;

  logic [nbits-1:0] qdata_q [2];
  logic [tbits-1:0] qtag_q  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;

  logic full, req_fire, enq, deq;

  // A full queue blocks enqueue even when the head is popped on the same edge.
  assign full     = (occ_q == 2'd2);
  assign req_rdy  = !x_val_q || !full;
  assign req_fire = req_val && req_rdy;
  assign enq      = x_val_q && !full;
  assign deq      = resp_val && resp_rdy;

  assign alu_op    = x_op_q;
  assign alu_in0   = x_in0_q;
  assign alu_in1   = x_in1_q;
  assign resp_val  = (occ_q != 2'd0);
  assign resp_data = qdata_q[rd_ptr_q];
  assign resp_tag  = qtag_q[rd_ptr_q];
  assign occ       = occ_q;

  // Next state of the X stage, pointers and occupancy.
  always_comb begin
    x_val_d  = x_val_q;
    x_op_d   = x_op_q;
    x_in0_d  = x_in0_q;
    x_in1_d  = x_in1_q;
    x_tag_d  = x_tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (req_fire) begin
      x_val_d = 1'b1;
      x_op_d  = req_op;
      x_in0_d = req_in0;
      x_in1_d = req_in1;
      x_tag_d = req_tag;
    end else if (enq) begin
      x_val_d = 1'b0;
    end
    if (enq) wr_ptr_d = !wr_ptr_q;
    if (deq) rd_ptr_d = !rd_ptr_q;
    occ_d = occ_q + {1'b0, enq} - {1'b0, deq};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_val_q  <= 1'b0;
      x_op_q   <= 1'b0;
      x_in0_q  <= '0;
      x_in1_q  <= '0;
      x_tag_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      x_val_q  <= x_val_d;
      x_op_q   <= x_op_d;
      x_in0_q  <= x_in0_d;
      x_in1_q  <= x_in1_d;
      x_tag_q  <= x_tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Response queue storage; the tail entry is written on enqueue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        qdata_q[i] <= '0;
        qtag_q[i]  <= '0;
      end
    end else if (enq) begin
      qdata_q[wr_ptr_q] <= alu_out;
      qtag_q[wr_ptr_q]  <= x_tag_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed testbench for alu_issue_unit with a behavioural combinational ALU.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_val;
  logic        req_rdy;
  logic        req_op;
  logic [31:0] req_in0;
  logic [31:0] req_in1;
  logic [3:0]  req_tag;
  logic        alu_op;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [31:0] alu_out;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_data;
  logic [3:0]  resp_tag;
  logic [1:0]  occ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: op 0 adds modulo 2^32, op 1 compares for equality.
  assign alu_out = alu_op ? {31'd0, (alu_in0 == alu_in1)} : (alu_in0 + alu_in1);

  alu_issue_unit #(.nbits(32), .tbits(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_op   (req_op),
    .req_in0  (req_in0),
    .req_in1  (req_in1),
    .req_tag  (req_tag),
    .alu_op   (alu_op),
    .alu_in0  (alu_in0),
    .alu_in1  (alu_in1),
    .alu_out  (alu_out),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_data(resp_data),
    .resp_tag (resp_tag),
    .occ      (occ)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
    req_val = 1'b1;
    req_op  = op;
    req_in0 = a;
    req_in1 = b;
    req_tag = t;
  endtask

  initial begin
    rst_n    = 1'b0;
    resp_rdy = 1'b0;
    drive(1'b1, 32'hAAAA5555, 32'h12345678, 4'hF);

    // Reset held two edges with a pending request: nothing loads.
    step();
    step();
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
    check("rst_resp_val", {31'd0, resp_val}, 32'd0);
    check("rst_occ", {30'd0, occ}, 32'd0);
    check("rst_alu_in0", alu_in0, 32'd0);
    check("rst_alu_in1", alu_in1, 32'd0);
    check("rst_alu_op", {31'd0, alu_op}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_tag", {28'd0, resp_tag}, 32'd0);

    // Single add, one X cycle of latency.
    rst_n = 1'b1;
    drive(1'b0, 32'd5, 32'd7, 4'd3);
    step();
    req_val = 1'b0;
    check("add_alu_in0", alu_in0, 32'd5);
    check("add_alu_in1", alu_in1, 32'd7);
    check("add_val_early", {31'd0, resp_val}, 32'd0);
    step();
    check("add_resp_val", {31'd0, resp_val}, 32'd1);
    check("add_resp_data", resp_data, 32'd12);
    check("add_resp_tag", {28'd0, resp_tag}, 32'd3);
    check("add_occ", {30'd0, occ}, 32'd1);
    resp_rdy = 1'b1;
    step();
    check("add_pop_occ", {30'd0, occ}, 32'd0);
    check("add_pop_val", {31'd0, resp_val}, 32'd0);

    // Back-to-back requests with the response side always ready.
    drive(1'b0, 32'hFFFFFFFF, 32'd1, 4'd1);
    step();
    drive(1'b1, 32'd9, 32'd9, 4'd2);
    step();
    check("b2b0_val", {31'd0, resp_val}, 32'd1);
    check("b2b0_data", resp_data, 32'd0);
    check("b2b0_tag", {28'd0, resp_tag}, 32'd1);
    drive(1'b1, 32'd9, 32'd8, 4'd3);
    step();
    req_val = 1'b0;
    check("b2b1_data", resp_data, 32'd1);
    check("b2b1_tag", {28'd0, resp_tag}, 32'd2);
    check("b2b1_occ", {30'd0, occ}, 32'd1);
    step();
    check("b2b2_val", {31'd0, resp_val}, 32'd1);
    check("b2b2_data", resp_data, 32'd0);
    check("b2b2_tag", {28'd0, resp_tag}, 32'd3);
    step();
    check("b2b_end_occ", {30'd0, occ}, 32'd0);

    // Backpressure: three requests accepted, the fourth stalls.
    resp_rdy = 1'b0;
    drive(1'b0, 32'd1, 32'd2, 4'd4);
    step();
    drive(1'b0, 32'd10, 32'd20, 4'd5);
    step();
    drive(1'b1, 32'd3, 32'd3, 4'd6);
    step();
    drive(1'b0, 32'd100, 32'd1, 4'd7);
    check("bp_rdy_low", {31'd0, req_rdy}, 32'd0);
    check("bp_occ_full", {30'd0, occ}, 32'd2);
    step();
    check("bp_rdy_hold", {31'd0, req_rdy}, 32'd0);
    check("bp_occ_hold", {30'd0, occ}, 32'd2);
    check("bp_x_hold", alu_in0, 32'd3);
    check("bp_head_data", resp_data, 32'd3);
    check("bp_head_tag", {28'd0, resp_tag}, 32'd4);
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    // Pop while full: X must not bypass into the freed slot on this edge.
    step();
    check("full_pop_occ", {30'd0, occ}, 32'd1);
    check("full_pop_data", resp_data, 32'd30);
    check("full_pop_tag", {28'd0, resp_tag}, 32'd5);
    check("full_pop_rdy", {31'd0, req_rdy}, 32'd1);
    step();
    check("drain2_occ", {30'd0, occ}, 32'd1);
    check("drain2_data", resp_data, 32'd1);
    check("drain2_tag", {28'd0, resp_tag}, 32'd6);
    step();
    check("drain_end_occ", {30'd0, occ}, 32'd0);
    check("drain_end_val", {31'd0, resp_val}, 32'd0);

    // Reset while full with X occupied discards everything.
    resp_rdy = 1'b0;
    drive(1'b0, 32'd11, 32'd1, 4'd8);
    step();
    drive(1'b0, 32'd22, 32'd1, 4'd9);
    step();
    drive(1'b0, 32'd33, 32'd1, 4'd10);
    step();
    req_val = 1'b0;
    check("mid_occ_full", {30'd0, occ}, 32'd2);
    check("mid_rdy_low", {31'd0, req_rdy}, 32'd0);
    rst_n = 1'b0;
    step();
    check("mid_rst_occ", {30'd0, occ}, 32'd0);
    check("mid_rst_val", {31'd0, resp_val}, 32'd0);
    check("mid_rst_rdy", {31'd0, req_rdy}, 32'd1);
    check("mid_rst_alu_in0", alu_in0, 32'd0);
    rst_n    = 1'b1;
    resp_rdy = 1'b1;
    step();
    step();
    check("mid_no_stale_val", {31'd0, resp_val}, 32'd0);
    check("mid_no_stale_occ", {30'd0, occ}, 32'd0);

    // Queue still works after the mid-operation reset.
    resp_rdy = 1'b0;
    drive(1'b0, 32'h80000000, 32'h80000001, 4'd12);
    step();
    req_val = 1'b0;
    step();
    check("post_rst_data", resp_data, 32'd1);
    check("post_rst_tag", {28'd0, resp_tag}, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
